// File: rtl/deassert_mon_pkg.sv
// rtl/deassert_mon_pkg.sv - shared state encoding and constants for deassert_monitor
package deassert_mon_pkg;

  localparam int STATE_W         = 2;
  localparam int MAX_LOW_DEFAULT = 10;

  typedef enum logic [STATE_W-1:0] {
    INIT    = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer with synchronous active-high reset
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture; both stages clear to 0 on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/deassert_monitor.sv
// rtl/deassert_monitor.sv - edge pulses, deassert count, low-run length and timeout; DEASSERT_MON_SYNC_EN adds an input synchronizer
module deassert_monitor
  import deassert_mon_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int RUN_W   = 6,
  parameter int MAX_LOW = MAX_LOW_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               sig_in,
  input  logic               clear,
  output logic               fall_pulse,
  output logic               rise_pulse,
  output logic [CNT_W-1:0]   deassert_count,
  output logic [RUN_W-1:0]   low_run,
  output logic [RUN_W-1:0]   last_low_len,
  output logic               timeout_err,
  output logic [STATE_W-1:0] mon_state
);

  localparam logic [RUN_W-1:0] RUN_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [RUN_W-1:0] MAX_LOW_V = RUN_W'(MAX_LOW);

  if (MAX_LOW < 1 || MAX_LOW > (2 ** RUN_W) - 1) begin : g_bad_max_low
    $error("deassert_monitor: MAX_LOW outside 1..2^RUN_W-1");
  end

  logic sample;
  logic sample_valid;

`ifdef DEASSERT_MON_SYNC_EN
  logic [1:0] warm;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (sig_in),
    .q     (sample)
  );

  // hold INIT until the synchronizer has flushed its reset value
  always_ff @(posedge clock) begin
    if (reset) warm <= '0;
    else       warm <= {warm[0], 1'b1};
  end

  assign sample_valid = warm[1];
`else
  assign sample       = sig_in;
  assign sample_valid = 1'b1;
`endif

  mon_state_e       state, state_nxt;
  logic             fall_nxt, rise_nxt, err_nxt;
  logic [CNT_W-1:0] count_base, count_nxt;
  logic [RUN_W-1:0] run_nxt, run_inc, last_nxt;

  // state and all registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= INIT;
      fall_pulse     <= 1'b0;
      rise_pulse     <= 1'b0;
      deassert_count <= '0;
      low_run        <= '0;
      last_low_len   <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      fall_pulse     <= fall_nxt;
      rise_pulse     <= rise_nxt;
      deassert_count <= count_nxt;
      low_run        <= run_nxt;
      last_low_len   <= last_nxt;
      timeout_err    <= err_nxt;
    end
  end

  // next state and output values; clear is applied first so a same-cycle event lands on top of it
  always_comb begin
    state_nxt  = state;
    fall_nxt   = 1'b0;
    rise_nxt   = 1'b0;
    count_base = clear ? '0 : deassert_count;
    count_nxt  = count_base;
    err_nxt    = clear ? 1'b0 : timeout_err;
    run_nxt    = low_run;
    last_nxt   = last_low_len;
    run_inc    = (low_run == RUN_MAX) ? low_run : low_run + RUN_W'(1);

    case (state)
      INIT: begin
        if (sample_valid) begin
          if (sample) begin
            state_nxt = HIGH;
          end else begin
            state_nxt = LOW;
            run_nxt   = RUN_W'(1);
          end
        end
      end
      HIGH: begin
        if (!sample) begin
          state_nxt = LOW;
          fall_nxt  = 1'b1;
          count_nxt = (count_base == CNT_MAX) ? count_base : count_base + CNT_W'(1);
          run_nxt   = RUN_W'(1);
        end
      end
      LOW, TIMEOUT: begin
        if (sample) begin
          state_nxt = HIGH;
          rise_nxt  = 1'b1;
          last_nxt  = low_run;
          run_nxt   = '0;
        end else begin
          run_nxt = run_inc;
        end
      end
      default: state_nxt = INIT;
    endcase

    // the run that just reached the limit trips the sticky error exactly once
    if (state != TIMEOUT && state_nxt == LOW && run_nxt == MAX_LOW_V) begin
      state_nxt = TIMEOUT;
      err_nxt   = 1'b1;
    end
  end

  assign mon_state = state;

endmodule
